// File: rtl/eq_check_pkg.sv
// Shared encodings for the masked streaming comparator: compare modes and lock FSM states.
package eq_check_pkg;

    localparam logic [1:0] MODE_EQ  = 2'b00;
    localparam logic [1:0] MODE_NEQ = 2'b01;
    localparam logic [1:0] MODE_LT  = 2'b10;
    localparam logic [1:0] MODE_GT  = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_HUNT   = 2'b01;
    localparam logic [1:0] ST_LOCKED = 2'b10;

endpackage

// File: rtl/eq_stream_checker_masked_compare.sv
// Masked operand compare: eq / neq / unsigned lt / unsigned gt on (a & mask) vs (b & mask).
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Masked-off bits read as zero on both sides, so an all-zero mask compares equal.
module masked_compare
    import eq_check_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] mask,
    input  logic [1:0]       mode,
    output logic             outcome
);

    logic [WIDTH-1:0] am;
    logic [WIDTH-1:0] bm;

    assign am = a & mask;
    assign bm = b & mask;

    always_comb begin
        outcome = 1'b0;
        case (mode)
            MODE_EQ:  outcome = (am == bm);
            MODE_NEQ: outcome = (am != bm);
            MODE_LT:  outcome = (am < bm);
            MODE_GT:  outcome = (am > bm);
            default:  outcome = 1'b0;
        endcase
    end

endmodule

// File: rtl/eq_stream_checker.sv
// Streaming masked comparator with registered result, saturating match counter and run-lock FSM.
// Latency: 1 cycle from accept to out_valid. Backpressure: in_ready = !out_valid || out_ready.
// A held result, together with its counter and FSM state, freezes until downstream consumes it.
module eq_stream_checker
    import eq_check_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 8,
    parameter int RUN_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] mask,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic [CNT_W-1:0] match_count,
    output logic             lock
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [7:0]       RUN_MAX = 8'(RUN_LEN);

    logic       accept;
    logic       cmp;
    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] run;
    logic [7:0] run_nxt;

    masked_compare #(.WIDTH(WIDTH)) u_cmp (
        .a       (a),
        .b       (b),
        .mask    (mask),
        .mode    (mode),
        .outcome (cmp)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign lock     = (state == ST_LOCKED);

    // Next FSM state assuming the current operand pair is accepted.
    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        case (state)
            ST_IDLE, ST_HUNT: begin
                if (cmp) begin
                    run_nxt   = (run >= RUN_MAX) ? RUN_MAX : run + 8'd1;
                    state_nxt = (run_nxt == RUN_MAX) ? ST_LOCKED : ST_HUNT;
                end else begin
                    run_nxt   = 8'd0;
                    state_nxt = ST_HUNT;
                end
            end
            ST_LOCKED: begin
                if (!cmp) begin
                    run_nxt   = 8'd0;
                    state_nxt = ST_HUNT;
                end
            end
            default: begin
                run_nxt   = 8'd0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            result      <= 1'b0;
            match_count <= '0;
            state       <= ST_IDLE;
            run         <= 8'd0;
        end else if (clear) begin
            // clear wins over a same-cycle accept; that operand pair is dropped
            out_valid   <= 1'b0;
            result      <= 1'b0;
            match_count <= '0;
            state       <= ST_IDLE;
            run         <= 8'd0;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= cmp;
            state     <= state_nxt;
            run       <= run_nxt;
            if (cmp && (match_count != CNT_MAX)) begin
                match_count <= match_count + 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_eq_stream_checker.sv
// Directed vector table plus hand-written multi-cycle sequences for the eq_stream_checker.
module tb_eq_stream_checker;

    localparam logic [1:0] EQ = 2'b00, NEQ = 2'b01, LT = 2'b10, GT = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] a = '0, b = '0, mask = '0;
    logic [1:0] mode = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready, out_valid, result, lock;
    logic [2:0] match_count;
    logic       u1_in_ready, u1_out_valid, u1_result, u1_lock;
    logic [0:0] u1_match_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    eq_stream_checker #(.WIDTH(8), .CNT_W(3), .RUN_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .a(a), .b(b), .mask(mask), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .match_count(match_count), .lock(lock)
    );

    // Minimal-width instance with immediate lock, driven by the same stream.
    eq_stream_checker #(.WIDTH(1), .CNT_W(1), .RUN_LEN(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .a(a[0:0]), .b(b[0:0]), .mask(mask[0:0]),
        .mode(mode), .in_valid(in_valid), .in_ready(u1_in_ready), .out_valid(u1_out_valid),
        .out_ready(out_ready), .result(u1_result), .match_count(u1_match_count), .lock(u1_lock)
    );

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] vmask;
        logic [1:0] vmode;
        logic       exp_result;
        logic [2:0] exp_count;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic ref_cmp(input logic [7:0] x, input logic [7:0] y,
                                     input logic [7:0] m, input logic [1:0] md);
        logic [7:0] xm, ym;
        xm = x & m;
        ym = y & m;
        case (md)
            EQ:      return xm == ym;
            NEQ:     return xm != ym;
            LT:      return xm < ym;
            default: return xm > ym;
        endcase
    endfunction

    // Called just after a rising edge; operand pair is accepted on the next edge.
    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] tm,
                        input logic [1:0] tmd);
        a = ta; b = tb; mask = tm; mode = tmd; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       m_ov, mrdy, r, m_lock;
        logic [2:0] m_cnt;
        int         m_run, acc, cons, cyc;
        logic       q[$];

        vecs[0]  = '{8'h5A, 8'h5A, 8'hFF, EQ,  1'b1, 3'd1};
        vecs[1]  = '{8'h5A, 8'h5B, 8'hFF, EQ,  1'b0, 3'd1};
        vecs[2]  = '{8'hF3, 8'h03, 8'h0F, EQ,  1'b1, 3'd2};
        vecs[3]  = '{8'hF3, 8'h03, 8'h0F, NEQ, 1'b0, 3'd2};
        vecs[4]  = '{8'h10, 8'h20, 8'hFF, LT,  1'b1, 3'd3};
        vecs[5]  = '{8'h10, 8'h20, 8'hFF, GT,  1'b0, 3'd3};
        vecs[6]  = '{8'h10, 8'h20, 8'h00, EQ,  1'b1, 3'd4};
        vecs[7]  = '{8'h10, 8'h20, 8'h00, LT,  1'b0, 3'd4};
        vecs[8]  = '{8'h10, 8'h20, 8'h00, GT,  1'b0, 3'd4};
        vecs[9]  = '{8'h10, 8'h20, 8'h00, NEQ, 1'b0, 3'd4};
        vecs[10] = '{8'h20, 8'h10, 8'hFF, GT,  1'b1, 3'd5};
        vecs[11] = '{8'hFF, 8'h00, 8'h80, GT,  1'b1, 3'd6};

        // Reset state
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_match_count", match_count, 0);
        chk("rst_lock", lock, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Vector table: one accept per entry, result checked one cycle later
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].va, vecs[i].vb, vecs[i].vmask, vecs[i].vmode);
            chk($sformatf("vec%0d_out_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_result", i), result, vecs[i].exp_result);
            chk($sformatf("vec%0d_count", i), match_count, vecs[i].exp_count);
            chk($sformatf("vec%0d_lock", i), lock, 0);
        end
        @(posedge clk); #1;
        chk("idle_out_valid", out_valid, 0);

        // Lock FSM
        do_clear();
        for (int i = 0; i < 4; i++) begin
            send(8'h33, 8'h33, 8'hFF, EQ);
            chk($sformatf("lock_run1_%0d", i), lock, (i == 3));
        end
        chk("u1_lock_true", u1_lock, 1);
        chk("u1_count_sat", u1_match_count, 1);
        send(8'h00, 8'h01, 8'hFF, EQ);
        chk("lock_after_false", lock, 0);
        chk("u1_lock_false", u1_lock, 0);
        for (int i = 0; i < 3; i++) begin
            send(8'h33, 8'h33, 8'hFF, EQ);
            chk($sformatf("lock_run2_%0d", i), lock, 0);
        end
        send(8'h33, 8'h33, 8'hFF, EQ);
        chk("lock_relock", lock, 1);

        // Backpressure: held result must not move while inputs churn
        do_clear();
        out_ready = 1'b0;
        send(8'h5A, 8'h5A, 8'hFF, EQ);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_result", result, 1);
        chk("bp_count", match_count, 1);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = 8'(i * 37); b = 8'(i * 11 + 1); mode = 2'(i); mask = 8'hFF;
            chk($sformatf("bp_in_ready_%0d", i), in_ready, 0);
            @(posedge clk); #1;
            chk($sformatf("bp_hold_result_%0d", i), result, 1);
            chk($sformatf("bp_hold_count_%0d", i), match_count, 1);
            chk($sformatf("bp_hold_valid_%0d", i), out_valid, 1);
        end
        a = 8'h00; b = 8'h01; mode = EQ; mask = 8'hFF;
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_next_result", result, 0);
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_count", match_count, 1);

        // Random transfers against a scoreboard
        do_clear();
        m_ov = 1'b0; m_cnt = '0; m_run = 0; m_lock = 1'b0; acc = 0; cons = 0;
        for (cyc = 0; cyc < 3000 && acc < 100; cyc++) begin
            a = 8'($urandom); b = 8'($urandom); mask = 8'($urandom); mode = 2'($urandom);
            if ($urandom_range(0, 3) == 0) b = a;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            mrdy = !m_ov || out_ready;
            chk("rnd_in_ready", in_ready, mrdy);
            chk("rnd_out_valid", out_valid, m_ov);
            if (m_ov && out_ready) begin
                chk("rnd_result", result, q[0]);
                void'(q.pop_front());
                cons++;
            end
            if (in_valid && mrdy) begin
                r = ref_cmp(a, b, mask, mode);
                q.push_back(r);
                acc++;
                m_ov = 1'b1;
                if (r) begin
                    if (m_cnt != 3'd7) m_cnt = m_cnt + 3'd1;
                    if (m_run < 4) m_run++;
                    m_lock = (m_run == 4);
                end else begin
                    m_run = 0;
                    m_lock = 1'b0;
                end
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("rnd_accepted", acc, 100);
        chk("rnd_count", match_count, m_cnt);
        chk("rnd_lock", lock, m_lock);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        if (m_ov) begin
            chk("rnd_last_result", result, q[0]);
            void'(q.pop_front());
            cons++;
        end
        @(posedge clk); #1;
        chk("rnd_consumed", cons, acc);
        chk("rnd_drained", out_valid, 0);

        // Saturation and clear priority
        do_clear();
        for (int i = 0; i < 10; i++) send(8'hC3, 8'hC3, 8'hFF, EQ);
        chk("sat_count", match_count, 7);
        chk("sat_lock", lock, 1);
        a = 8'h77; b = 8'h77; mask = 8'hFF; mode = EQ;
        clear = 1'b1; in_valid = 1'b1;
        #1;
        chk("clear_in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("clear_count", match_count, 0);
        chk("clear_valid", out_valid, 0);
        chk("clear_lock", lock, 0);
        clear = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("clear_dropped_count", match_count, 0);
        chk("clear_dropped_valid", out_valid, 0);

        // Asynchronous reset while holding a result in LOCKED
        for (int i = 0; i < 3; i++) send(8'h11, 8'h11, 8'hFF, EQ);
        a = 8'h11; b = 8'h11; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_lock", lock, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_result", result, 0);
        chk("arst_count", match_count, 0);
        chk("arst_lock", lock, 0);
        chk("arst_in_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
